wb_stage_pipe: RTL and testbench
================================

# wb_stage_pipe

Registered, parametrised write-back stage for the 32I core, sitting between the MEM stage and the register file write port. It captures one retiring instruction per cycle and selects among PC+4, load data, ALU result and CSR read data. It extracts and extends sub-word loads, drives the register-file write port and a forwarding tap, and counts retired instructions.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- RA_W, 5: register address width.
- CNT_W, 64: retired-instruction counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM stage presents a retiring instruction.
- in_ready  out  1  stage accepts this cycle; equals !stall.
- stall  in  1  hold the stage register; no capture.
- flush  in  1  kill the captured entry and any entry being offered.
- pc4  in  XLEN  PC+4 of the instruction.
- mem_data  in  XLEN  raw aligned load word from data memory.
- alu_result  in  XLEN  ALU result; low bits are also the load address.
- csr_data  in  XLEN  CSR read value.
- mem_to_reg  in  2  source select: 0 PC4, 1 MEMDATA, 2 ALURESULT, 3 CSR.
- funct3  in  3  load type.
- reg_write  in  1  instruction writes rd.
- rd  in  RA_W  destination register.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  RA_W  register-file write address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- fwd_valid, fwd_rd, fwd_data  out  1/RA_W/XLEN  forwarding tap; mirrors rf_we/rf_waddr/rf_wdata.
- instret  out  CNT_W  retired-instruction count.

## Operation
- Capture condition: in_valid && !stall && !flush.
- On capture, the stage register loads the following:
  - the selected write data;
  - we = reg_write && (rd != 0);
  - the rd address;
  - valid = 1.
- No capture and no stall: valid clears, we clears, and the data and address registers hold.
- Stall: the whole register holds, including valid and we.
- Flush: priority over stall and capture. On the next edge valid=0 and we=0; data holds.
- Select: 0 selects pc4, 1 the extended load, 2 alu_result, 3 csr_data.
- Load extension uses addr = alu_result[1:0].
  - LB (000): byte mem_data[8*addr +: 8], sign-extended.
  - LBU (100): same byte, zero-extended.
  - LH (001): half mem_data[16*addr[1] +: 16], sign-extended. addr[0] is ignored.
  - LHU (101): same half, zero-extended.
  - LW (010) and all other codes: mem_data[31:0], sign-extended to XLEN.
- instret increments by 1 on every edge where the register holds valid=1 and stall=0 and flush=0, i.e. on retirement.
  - Retirement is counted regardless of we (stores, branches, rd=x0).
  - Wraps modulo 2^CNT_W.
- An entry retires exactly once, even if stall holds it for many cycles.
- rf_we is asserted only while stall=0. A stalled entry writes the register file once, on its retiring cycle.

## Timing
- Latency is 1 cycle: the instruction captured at edge N is on rf_* and fwd_* after edge N.
- The register-file write happens at edge N+1 if stall is low.
- in_ready is combinational from stall.
- The forwarding tap is valid in the same cycle as rf_*.
- Reset (rst_n low, asynchronous) clears the following to 0:
  - rf_we, rf_waddr, rf_wdata;
  - fwd_valid, fwd_rd, fwd_data;
  - the valid bit;
  - instret.
- Reset deasserted mid-stream: the first capture occurs at the first edge with rst_n high.
- Simultaneous flush, stall and in_valid: flush wins, the entry is dropped and not counted.

## Configuration
- WB_LOAD_EXT_EN defined: sub-word extraction and extension as specified above.
- WB_LOAD_EXT_EN undefined:
  - source 1 passes mem_data through unmodified;
  - funct3 and alu_result[1:0] are ignored;
  - the core must then extend loads in the LSU.

## Test plan
- Reset: assert rst_n=0 mid-run with instret=5 and rf_we=1 -> all outputs and instret read 0 immediately, without waiting for a clock edge.
- Select: capture mem_to_reg=0,1,2,3 with pc4=0x104, mem_data=0xCAFEBABE, alu_result=0x20, csr_data=0x1800, funct3=010, rd=3 -> rf_wdata is 0x104, 0xCAFEBABE, 0x20, 0x1800 on consecutive cycles. instret rises by 4.
- Load extension with WB_LOAD_EXT_EN, mem_data=0x80F07F12:
  - LB addr=2 -> 0xFFFFFFF0;
  - LBU addr=3 -> 0x00000080;
  - LH addr=2 -> 0xFFFF80F0;
  - LHU addr=0 -> 0x00007F12.
- x0 suppression: reg_write=1, rd=0 -> rf_we=0, fwd_valid=0, instret increments.
- Stall/flush:
  - Stall 3 cycles after capture -> rf_we=0 during the stall, one rf_we pulse after release, instret +1 exactly once.
  - Flush during a stall -> no write, no count.
- Counter wrap: CNT_W=4, 17 back-to-back retirements -> instret=1.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
//
// Registered write-back stage for the 32I core. Sits between the MEM stage
// and the register-file write port. One retiring instruction is captured per
// cycle; its write-back value is selected from PC+4, (extended) load data,
// ALU result or CSR read data. The captured entry drives the register-file
// write port and an identical forwarding tap one cycle later. A retired
// instruction counter advances once per retiring entry.
//
// Compile-time option:
//   WB_LOAD_EXT_EN  defined   -> sub-word load extraction and sign/zero
//                                extension (LB/LBU/LH/LHU/LW) done here.
//                   undefined -> load data (source 1) passes through
//                                unmodified; funct3 and alu_result[1:0] are
//                                not used for loads and the LSU must extend.
//
// Parameters:
//   XLEN   datapath width (32 or 64)
//   RA_W   register address width
//   CNT_W  retired-instruction counter width
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         MEM stage offers an instruction / stage accepts
//   stall                       hold the stage register (no capture, no retire)
//   flush                       kill the held entry and any offered entry
//   pc4, mem_data, alu_result,  candidate write-back sources
//   csr_data
//   mem_to_reg                  source select (0 pc4, 1 load, 2 alu, 3 csr)
//   funct3                      load type
//   reg_write, rd               instruction writes rd / destination register
//   rf_we, rf_waddr, rf_wdata   register-file write port
//   fwd_valid, fwd_rd, fwd_data forwarding tap, mirrors the write port
//   instret                     retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module wb_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,

    input  logic [XLEN-1:0]  pc4,
    input  logic [XLEN-1:0]  mem_data,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  csr_data,
    input  logic [1:0]       mem_to_reg,
    input  logic [2:0]       funct3,
    input  logic             reg_write,
    input  logic [RA_W-1:0]  rd,

    output logic             rf_we,
    output logic [RA_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,

    output logic             fwd_valid,
    output logic [RA_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,

    output logic [CNT_W-1:0] instret
);

    // -------------------------------------------------------------------------
    // Encodings
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        SRC_PC4 = 2'd0,
        SRC_MEM = 2'd1,
        SRC_ALU = 2'd2,
        SRC_CSR = 2'd3
    } wb_src_e;

    typedef enum logic [2:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_type_e;

    // -------------------------------------------------------------------------
    // Stage register
    // -------------------------------------------------------------------------
    logic             valid_q, valid_d;
    logic             we_q,    we_d;
    logic [RA_W-1:0]  waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             capture;
    logic             retire;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  sel_data;

    // Back-pressure is purely a function of stall; flush does not block the
    // handshake, it just discards whatever is offered.
    assign in_ready = !stall;

    assign capture  = in_valid && !stall && !flush;

    // The held entry leaves the stage on any edge where it is neither held
    // by stall nor killed by flush. A stalled entry therefore retires only
    // once, on its release cycle.
    assign retire   = valid_q && !stall && !flush;

    // -------------------------------------------------------------------------
    // Load extraction / extension
    // -------------------------------------------------------------------------
`ifdef WB_LOAD_EXT_EN
    logic [1:0]  load_addr;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign load_addr = alu_result[1:0];

    // NOTE: every variable assigned in this block gets a value before the
    // case statements, so no path leaves it unassigned and no latch is
    // inferred.
    always_comb begin
        load_byte = mem_data[7:0];
        load_half = mem_data[15:0];
        load_data = XLEN'($signed(mem_data[31:0]));

        case (load_addr)
            2'd0:    load_byte = mem_data[7:0];
            2'd1:    load_byte = mem_data[15:8];
            2'd2:    load_byte = mem_data[23:16];
            default: load_byte = mem_data[31:24];
        endcase

        // Halfword select uses addr[1] only; a misaligned addr[0] is ignored.
        load_half = load_addr[1] ? mem_data[31:16] : mem_data[15:0];

        case (load_type_e'(funct3))
            LD_B:    load_data = XLEN'($signed(load_byte));
            LD_BU:   load_data = XLEN'(load_byte);
            LD_H:    load_data = XLEN'($signed(load_half));
            LD_HU:   load_data = XLEN'(load_half);
            // LW and every unassigned code return the low word,
            // sign-extended when XLEN is 64.
            default: load_data = XLEN'($signed(mem_data[31:0]));
        endcase
    end
`else
    // Extension happens in the LSU; the raw word is written back as is.
    assign load_data = mem_data;

    logic unused_load_ctl;
    assign unused_load_ctl = ^funct3;
`endif

    // -------------------------------------------------------------------------
    // Write-back source select
    // -------------------------------------------------------------------------
    always_comb begin
        sel_data = pc4;
        case (wb_src_e'(mem_to_reg))
            SRC_PC4: sel_data = pc4;
            SRC_MEM: sel_data = load_data;
            SRC_ALU: sel_data = alu_result;
            SRC_CSR: sel_data = csr_data;
            default: sel_data = pc4;
        endcase
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // Priority: flush > stall > capture > bubble.
    // Address and data registers are only loaded on capture; a bubble or a
    // flush clears valid/we but leaves the last written value visible.
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (stall) begin
            // Hold the entire stage register.
            valid_d = valid_q;
            we_d    = we_q;
        end else if (capture) begin
            valid_d = 1'b1;
            // Writes to x0 are dropped here so the RF and forwarding
            // network never see them; the instruction still retires.
            we_d    = reg_write && (rd != '0);
            waddr_d = rd;
            wdata_d = sel_data;
        end else begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end
    end

    // Counter wraps naturally at 2^CNT_W.
    assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of the
    // order of statements or blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            instret_q <= '0;
        end else begin
            valid_q   <= valid_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            instret_q <= instret_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The write enable is the registered we bit qualified by the current
    // stall/flush: a held entry must not write on every stalled cycle, only
    // on the cycle it actually retires, and a killed entry never writes.
    assign rf_we     = valid_q && we_q && !stall && !flush;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;

    // Forwarding tap is a straight copy of the write port, same cycle.
    assign fwd_valid = rf_we;
    assign fwd_rd    = waddr_q;
    assign fwd_data  = wdata_q;

    assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_stage_pipe
//
// Self-checking bench for wb_stage_pipe. Two instances share all inputs: one
// with the default 64-bit retire counter and one with CNT_W=4 for the wrap
// case. Expected values come from constant tables and from a small
// transaction-level reference model (one pending retirement plus an integer
// retire count) evaluated from the stage's rules.
// -----------------------------------------------------------------------------
module tb_wb_stage_pipe;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

`ifdef WB_LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    typedef struct {
        bit          in_valid;
        bit          stall;
        bit          flush;
        logic [31:0] pc4;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] csr;
        logic [1:0]  m2r;
        logic [2:0]  f3;
        bit          rw;
        logic [4:0]  rd;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic [31:0] exp_data;
        bit          exp_we;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic            in_valid, stall, flush;
    logic [XLEN-1:0] pc4, mem_data, alu_result, csr_data;
    logic [1:0]      mem_to_reg;
    logic [2:0]      funct3;
    logic            reg_write;
    logic [RA_W-1:0] rd;

    logic            in_ready, rf_we, fwd_valid;
    logic [RA_W-1:0] rf_waddr, fwd_rd;
    logic [XLEN-1:0] rf_wdata, fwd_data;
    logic [63:0]     instret;

    logic            in_ready4, rf_we4, fwd_valid4;
    logic [RA_W-1:0] rf_waddr4, fwd_rd4;
    logic [XLEN-1:0] rf_wdata4, fwd_data4;
    logic [3:0]      instret4;

    wb_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .stall(stall), .flush(flush),
        .pc4(pc4), .mem_data(mem_data), .alu_result(alu_result), .csr_data(csr_data),
        .mem_to_reg(mem_to_reg), .funct3(funct3), .reg_write(reg_write), .rd(rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .instret(instret)
    );

    wb_stage_pipe #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4), .stall(stall), .flush(flush),
        .pc4(pc4), .mem_data(mem_data), .alu_result(alu_result), .csr_data(csr_data),
        .mem_to_reg(mem_to_reg), .funct3(funct3), .reg_write(reg_write), .rd(rd),
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4),
        .instret(instret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the one instruction waiting to retire, the last
    // value written into the stage, and the number of retirements so far.
    bit              m_valid;
    bit              m_we;
    logic [4:0]      m_rd;
    logic [31:0]     m_data;
    longint unsigned m_cnt;

    bit obs_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        int unsigned b, h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * (a / 2))) & 32'hFFFF;
        if (!EXT) return w;
        case (f3)
            3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_sel(input stim_t s);
        case (s.m2r)
            2'd0:    return s.pc4;
            2'd1:    return ref_load(s.mem, s.f3, s.alu[1:0]);
            2'd2:    return s.alu;
            default: return s.csr;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0; m_cnt = 0;
    endtask

    task automatic model_step(input stim_t s);
        if (m_valid && !s.stall && !s.flush) m_cnt++;
        if (s.flush) m_valid = 1'b0;
        else if (!s.stall) begin
            if (s.in_valid) begin
                m_valid = 1'b1;
                m_we    = s.rw && (s.rd != 0);
                m_rd    = s.rd;
                m_data  = ref_sel(s);
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic drive(input stim_t s);
        in_valid = s.in_valid; stall = s.stall; flush = s.flush;
        pc4 = s.pc4; mem_data = s.mem; alu_result = s.alu; csr_data = s.csr;
        mem_to_reg = s.m2r; funct3 = s.f3; reg_write = s.rw; rd = s.rd;
    endtask

    task automatic check_outs();
        bit ew;
        ew = m_valid && m_we && !stall && !flush;
        check("in_ready",   64'(in_ready),   64'(!stall));
        check("rf_we",      64'(rf_we),      64'(ew));
        check("fwd_valid",  64'(fwd_valid),  64'(ew));
        check("rf_waddr",   64'(rf_waddr),   64'(m_rd));
        check("fwd_rd",     64'(fwd_rd),     64'(m_rd));
        check("rf_wdata",   64'(rf_wdata),   64'(m_data));
        check("fwd_data",   64'(fwd_data),   64'(m_data));
        check("instret",    instret,         m_cnt);
        check("instret4",   64'(instret4),   64'(m_cnt % 16));
        check("rf_we4",     64'(rf_we4),     64'(ew));
        check("fwd_valid4", 64'(fwd_valid4), 64'(ew));
        check("in_ready4",  64'(in_ready4),  64'(!stall));
        check("rf_waddr4",  64'(rf_waddr4),  64'(fwd_rd4 == m_rd ? m_rd : ~m_rd));
        check("rf_wdata4",  64'(rf_wdata4),  64'(fwd_data4 == m_data ? m_data : ~m_data));
    endtask

    // One clock: drive at the falling edge, check before the rising edge,
    // advance the model on the rising edge, return at the next falling edge.
    task automatic cycle(input stim_t s);
        drive(s);
        #1;
        check_outs();
        obs_we = rf_we;
        @(posedge clk);
        model_step(s);
        @(negedge clk);
    endtask

    function automatic stim_t mk(input logic [1:0] m2r, input logic [2:0] f3,
                                 input logic [31:0] alu, input logic [31:0] mem,
                                 input bit rw, input logic [4:0] r);
        stim_t s;
        s.in_valid = 1'b1; s.stall = 1'b0; s.flush = 1'b0;
        s.pc4 = 32'h104; s.csr = 32'h1800;
        s.m2r = m2r; s.f3 = f3; s.alu = alu; s.mem = mem; s.rw = rw; s.rd = r;
        return s;
    endfunction

    function automatic stim_t ctl(input stim_t base, input bit v, input bit st, input bit fl);
        stim_t s;
        s = base; s.in_valid = v; s.stall = st; s.flush = fl;
        return s;
    endfunction

    vec_t  tbl[15];
    stim_t idle;

    initial begin
        longint unsigned c0;
        int pulses;
        stim_t s;

        idle = ctl(mk(2'd2, 3'b010, 32'h0, 32'h0, 1'b0, 5'd0), 1'b0, 1'b0, 1'b0);

        tbl[0]  = '{mk(2'd0, 3'b010, 32'h20, 32'hCAFEBABE, 1'b1, 5'd3), 32'h104, 1'b1};
        tbl[1]  = '{mk(2'd1, 3'b010, 32'h20, 32'hCAFEBABE, 1'b1, 5'd3), 32'hCAFEBABE, 1'b1};
        tbl[2]  = '{mk(2'd2, 3'b010, 32'h20, 32'hCAFEBABE, 1'b1, 5'd3), 32'h20, 1'b1};
        tbl[3]  = '{mk(2'd3, 3'b010, 32'h20, 32'hCAFEBABE, 1'b1, 5'd3), 32'h1800, 1'b1};
        tbl[4]  = '{mk(2'd1, 3'b000, 32'h1002, 32'h80F07F12, 1'b1, 5'd3),
                    EXT ? 32'hFFFFFFF0 : 32'h80F07F12, 1'b1};
        tbl[5]  = '{mk(2'd1, 3'b100, 32'h0003, 32'h80F07F12, 1'b1, 5'd3),
                    EXT ? 32'h00000080 : 32'h80F07F12, 1'b1};
        tbl[6]  = '{mk(2'd1, 3'b001, 32'h0002, 32'h80F07F12, 1'b1, 5'd3),
                    EXT ? 32'hFFFF80F0 : 32'h80F07F12, 1'b1};
        tbl[7]  = '{mk(2'd1, 3'b101, 32'h0000, 32'h80F07F12, 1'b1, 5'd3),
                    EXT ? 32'h00007F12 : 32'h80F07F12, 1'b1};
        tbl[8]  = '{mk(2'd1, 3'b001, 32'h0003, 32'h80F07F12, 1'b1, 5'd4),
                    EXT ? 32'hFFFF80F0 : 32'h80F07F12, 1'b1};
        tbl[9]  = '{mk(2'd1, 3'b000, 32'h0001, 32'h80F07F12, 1'b1, 5'd5),
                    EXT ? 32'h0000007F : 32'h80F07F12, 1'b1};
        tbl[10] = '{mk(2'd1, 3'b000, 32'h0000, 32'h80F07F12, 1'b1, 5'd6),
                    EXT ? 32'h00000012 : 32'h80F07F12, 1'b1};
        tbl[11] = '{mk(2'd1, 3'b011, 32'h0001, 32'h80F07F12, 1'b1, 5'd7), 32'h80F07F12, 1'b1};
        tbl[12] = '{mk(2'd1, 3'b110, 32'h0002, 32'h80F07F12, 1'b1, 5'd8), 32'h80F07F12, 1'b1};
        tbl[13] = '{mk(2'd2, 3'b010, 32'h55, 32'h0, 1'b1, 5'd0), 32'h55, 1'b0};
        tbl[14] = '{mk(2'd2, 3'b010, 32'h66, 32'h0, 1'b0, 5'd5), 32'h66, 1'b0};

        // ---------------- power-on reset ----------------
        rst_n = 1'b0;
        drive(idle);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // ---------------- asynchronous reset mid-run ----------------
        for (int i = 0; i < 6; i++) cycle(mk(2'd2, 3'b010, 32'h40 + i, 32'h0, 1'b1, 5'(i + 1)));
        check("pre_rst_rf_we", 64'(rf_we), 64'd1);
        check("pre_rst_instret", instret, 64'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_rf_we",     64'(rf_we),     64'd0);
        check("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        check("rst_rf_waddr",  64'(rf_waddr),  64'd0);
        check("rst_rf_wdata",  64'(rf_wdata),  64'd0);
        check("rst_fwd_rd",    64'(fwd_rd),    64'd0);
        check("rst_fwd_data",  64'(fwd_data),  64'd0);
        check("rst_instret",   instret,        64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- counter wrap (CNT_W=4) ----------------
        for (int i = 0; i < 17; i++) cycle(mk(2'd2, 3'b010, 32'h100 + i, 32'h0, 1'b1, 5'd9));
        cycle(idle);
        check("wrap_instret4", 64'(instret4), 64'd1);
        check("wrap_instret",  instret,       64'd17);

        // ---------------- source select ----------------
        c0 = instret;
        for (int i = 0; i < 4; i++) begin
            cycle(tbl[i].s);
            check($sformatf("tbl%0d_wdata", i), 64'(rf_wdata), 64'(tbl[i].exp_data));
            check($sformatf("tbl%0d_we", i),    64'(rf_we),    64'(tbl[i].exp_we));
        end
        cycle(idle);
        check("select_instret_delta", instret - c0, 64'd4);

        // ---------------- load extension and x0 suppression ----------------
        for (int i = 4; i < 15; i++) begin
            cycle(tbl[i].s);
            check($sformatf("tbl%0d_wdata", i), 64'(rf_wdata), 64'(tbl[i].exp_data));
            check($sformatf("tbl%0d_we", i),    64'(rf_we),    64'(tbl[i].exp_we));
            check($sformatf("tbl%0d_fwd", i),   64'(fwd_valid), 64'(tbl[i].exp_we));
        end
        c0 = instret;
        cycle(idle);
        check("x0_retire_counted", instret - c0, 64'd1);

        // ---------------- stall 3 cycles after capture ----------------
        s = mk(2'd2, 3'b010, 32'hABC, 32'h0, 1'b1, 5'd7);
        c0 = instret;
        pulses = 0;
        cycle(s);
        for (int i = 0; i < 3; i++) begin
            cycle(ctl(mk(2'd2, 3'b010, 32'hDEAD, 32'h0, 1'b1, 5'd8), 1'b1, 1'b1, 1'b0));
            check("stall_no_we", 64'(obs_we), 64'd0);
            pulses += int'(obs_we);
        end
        check("stall_held_data", 64'(rf_wdata), 64'h0ABC);
        for (int i = 0; i < 3; i++) begin
            cycle(idle);
            pulses += int'(obs_we);
        end
        check("stall_one_pulse", 64'(pulses), 64'd1);
        check("stall_count_once", instret - c0, 64'd1);

        // ---------------- flush during stall ----------------
        c0 = instret;
        pulses = 0;
        cycle(mk(2'd2, 3'b010, 32'h777, 32'h0, 1'b1, 5'd9));
        cycle(ctl(s, 1'b1, 1'b1, 1'b0));
        pulses += int'(obs_we);
        cycle(ctl(s, 1'b1, 1'b1, 1'b1));
        pulses += int'(obs_we);
        for (int i = 0; i < 3; i++) begin
            cycle(idle);
            pulses += int'(obs_we);
        end
        check("flush_no_write", 64'(pulses), 64'd0);
        check("flush_no_count", instret - c0, 64'd0);
        check("flush_data_hold", 64'(rf_wdata), 64'h777);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            s.in_valid = ($urandom_range(0, 3) != 0);
            s.stall    = ($urandom_range(0, 3) == 0);
            s.flush    = ($urandom_range(0, 9) == 0);
            s.pc4      = $urandom;
            s.mem      = $urandom;
            s.alu      = $urandom;
            s.csr      = $urandom;
            s.m2r      = 2'($urandom_range(0, 3));
            s.f3       = 3'($urandom_range(0, 7));
            s.rw       = ($urandom_range(0, 3) != 0);
            s.rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(s);
        end
        cycle(idle);
        check_outs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
